// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: opcodes, error codes and state encoding shared by the loop sequencer.
`default_nettype none
package loop_ctrl_pkg;
  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd3;

  typedef enum logic [1:0] {
    LC_RUN  = 2'd0,
    LC_SKIP = 2'd1,
    LC_DONE = 2'd2,
    LC_HALT = 2'd3
  } lc_state_t;
endpackage
`default_nettype wire

// File: rtl/loop_skip_counter.sv
// loop_skip_counter: nesting depth counter used while scanning over a skipped loop body.
`default_nettype none
module loop_skip_counter #(
  parameter int NEST_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load_one,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_is_one,
  output logic o_is_max
);
  localparam logic [NEST_WIDTH-1:0] c_ONE = {{(NEST_WIDTH-1){1'b0}}, 1'b1};

  logic [NEST_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load_one) begin
      r_count <= c_ONE;
    end else if (i_inc && !o_is_max) begin
      r_count <= r_count + c_ONE;
    end else if (i_dec) begin
      r_count <= r_count - c_ONE;
    end
  end

  assign o_is_one = (r_count == c_ONE);
  assign o_is_max = &r_count;
endmodule
`default_nettype wire

// File: rtl/loop_ctrl.sv
// loop_ctrl: '[' / ']' sequencer driving the external loop stack, with forward skip scan.
// Optional macro LOOP_HWM_EN enables the stack depth high-water-mark register.
`default_nettype none
module loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int DEPTH_WIDTH = 5,
  parameter int NEST_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   insn_valid,
  input  logic [7:0]             insn,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   cell_zero,
  input  logic                   prog_end,
  output logic                   insn_ack,
  output logic                   skipping,
  output logic                   branch_en,
  output logic [PC_WIDTH-1:0]    branch_pc,
  output logic [PC_WIDTH-1:0]    stk_pushd,
  output logic                   stk_push_en,
  output logic                   stk_pop_en,
  input  logic [PC_WIDTH-1:0]    stk_top,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [DEPTH_WIDTH:0]   hwm
);
  localparam logic [DEPTH_WIDTH:0] c_MAXD = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] c_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  lc_state_t              r_state;
  logic [DEPTH_WIDTH:0]   r_depth;
  logic                   r_done;
  logic                   r_error;
  logic [1:0]             r_err_code;

  lc_state_t              w_next;
  logic                   w_ack, w_skip, w_push, w_pop, w_branch;
  logic                   w_set_done, w_set_err;
  logic [1:0]             w_err;
  logic                   w_nest_load, w_nest_inc, w_nest_dec;
  logic                   w_nest_is_one, w_nest_is_max;
  logic [DEPTH_WIDTH:0]   w_depth_inc;

  loop_skip_counter #(.NEST_WIDTH(NEST_WIDTH)) u_skip_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load_one (w_nest_load),
    .i_inc      (w_nest_inc),
    .i_dec      (w_nest_dec),
    .o_is_one   (w_nest_is_one),
    .o_is_max   (w_nest_is_max)
  );

  assign w_depth_inc = r_depth + c_ONE;

  // Everything here is forced low while rst is high so the stack sees no stray ops.
  always_comb begin
    w_next      = r_state;
    w_ack       = 1'b0;
    w_skip      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_branch    = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_err       = ERR_NONE;
    w_nest_load = 1'b0;
    w_nest_inc  = 1'b0;
    w_nest_dec  = 1'b0;
    if (!rst) begin
      case (r_state)
        LC_RUN: begin
          if (prog_end) begin
            if (r_depth == '0) begin
              w_next     = LC_DONE;
              w_set_done = 1'b1;
            end else begin
              w_next    = LC_HALT;
              w_set_err = 1'b1;
              w_err     = ERR_UNCLOSED;
            end
          end else if (insn_valid) begin
            if (insn == OP_LOOP_OPEN) begin
              if (cell_zero) begin
                w_ack       = 1'b1;
                w_skip      = 1'b1;
                w_nest_load = 1'b1;
                w_next      = LC_SKIP;
              end else if (r_depth == c_MAXD) begin
                w_next    = LC_HALT;
                w_set_err = 1'b1;
                w_err     = ERR_OVERFLOW;
              end else begin
                w_ack  = 1'b1;
                w_push = 1'b1;
              end
            end else if (insn == OP_LOOP_CLOSE) begin
              if (r_depth == '0) begin
                w_next    = LC_HALT;
                w_set_err = 1'b1;
                w_err     = ERR_UNMATCHED;
              end else if (cell_zero) begin
                w_ack = 1'b1;
                w_pop = 1'b1;
              end else begin
                w_ack    = 1'b1;
                w_branch = 1'b1;
              end
            end else begin
              w_ack = 1'b1;
            end
          end
        end
        LC_SKIP: begin
          if (prog_end) begin
            w_next    = LC_HALT;
            w_set_err = 1'b1;
            w_err     = ERR_UNCLOSED;
          end else if (insn_valid) begin
            w_ack  = 1'b1;
            w_skip = 1'b1;
            if (insn == OP_LOOP_OPEN) begin
              if (w_nest_is_max) begin
                w_next    = LC_HALT;
                w_set_err = 1'b1;
                w_err     = ERR_UNCLOSED;
              end else begin
                w_nest_inc = 1'b1;
              end
            end else if (insn == OP_LOOP_CLOSE) begin
              w_nest_dec = 1'b1;
              if (w_nest_is_one) begin
                w_next = LC_RUN;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LC_RUN;
      r_depth    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_depth <= w_depth_inc;
      end else if (w_pop) begin
        r_depth <= r_depth - c_ONE;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_code <= w_err;
      end
    end
  end

`ifdef LOOP_HWM_EN
  logic [DEPTH_WIDTH:0] r_hwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (w_push && (w_depth_inc > r_hwm)) begin
      r_hwm <= w_depth_inc;
    end
  end

  assign hwm = r_hwm;
`else
  assign hwm = '0;
`endif

  assign insn_ack    = w_ack;
  assign skipping    = w_skip;
  assign branch_en   = w_branch;
  assign stk_push_en = w_push;
  assign stk_pop_en  = w_pop;
  assign branch_pc   = rst ? '0 : stk_top + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign stk_pushd   = rst ? '0 : pc;
  assign done        = r_done;
  assign error       = r_error;
  assign err_code    = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: table-driven scoreboard bench for loop_ctrl with a behavioural loop stack.
`default_nettype none
module tb_loop_ctrl;
  import loop_ctrl_pkg::*;

  localparam int PCW = 16;
  localparam int DW  = 5;
  localparam int NW  = 8;

  // expected-output bit layout: ack skip br push pop done error code[1:0]
  localparam logic [8:0] E_NONE = 9'h000;
  localparam logic [8:0] E_ACK  = 9'h100;
  localparam logic [8:0] E_SKIP = 9'h180;
  localparam logic [8:0] E_BR   = 9'h140;
  localparam logic [8:0] E_PUSH = 9'h120;
  localparam logic [8:0] E_POP  = 9'h110;
  localparam logic [8:0] E_DONE = 9'h008;
  localparam logic [8:0] E_ERR1 = 9'h005;
  localparam logic [8:0] E_ERR2 = 9'h006;
  localparam logic [8:0] E_ERR3 = 9'h007;
  localparam logic [8:0] M_ALL  = 9'h1FF;
  localparam logic [8:0] M_COMB = 9'h1F0;
  localparam logic [7:0] OP_PLUS  = 8'h2B;
  localparam logic [7:0] OP_MINUS = 8'h2D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           insn_valid = 1'b0;
  logic [7:0]     insn = 8'h00;
  logic [PCW-1:0] pc = '0;
  logic           cell_zero = 1'b0;
  logic           prog_end = 1'b0;
  logic           insn_ack, skipping, branch_en, stk_push_en, stk_pop_en;
  logic [PCW-1:0] branch_pc, stk_pushd, stk_top;
  logic           done, error;
  logic [1:0]     err_code;
  logic [DW:0]    hwm;

  loop_ctrl #(.PC_WIDTH(PCW), .DEPTH_WIDTH(DW), .NEST_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .insn_valid(insn_valid), .insn(insn), .pc(pc),
    .cell_zero(cell_zero), .prog_end(prog_end), .insn_ack(insn_ack),
    .skipping(skipping), .branch_en(branch_en), .branch_pc(branch_pc),
    .stk_pushd(stk_pushd), .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en),
    .stk_top(stk_top), .done(done), .error(error), .err_code(err_code), .hwm(hwm)
  );

  // behavioural LIFO standing in for the core's stack
  logic [PCW-1:0] stk_mem [0:63];
  logic [6:0]     sp = '0;
  always @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (stk_push_en) begin
      stk_mem[sp[5:0]] <= stk_pushd;
      sp <= sp + 7'd1;
    end else if (stk_pop_en) begin
      sp <= sp - 7'd1;
    end
  end
  assign stk_top = (sp != 7'd0) ? stk_mem[sp[5:0] - 6'd1] : '0;

  typedef struct {
    int             tid;
    logic           r;
    logic           v;
    logic [7:0]     ins;
    logic [PCW-1:0] pc;
    logic           cz;
    logic           pe;
    logic [8:0]     ex;
    logic [8:0]     msk;
    logic [PCW-1:0] bpc;
    logic           hc;
    logic [DW:0]    hv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_t = 0;

  function automatic logic [DW:0] hw(input logic [DW:0] x);
`ifdef LOOP_HWM_EN
    return x;
`else
    return (x & '0);
`endif
  endfunction

  function automatic void add(input logic r, input logic v, input logic [7:0] ins,
                              input logic [PCW-1:0] p, input logic cz, input logic pe,
                              input logic [8:0] ex, input logic [8:0] msk,
                              input logic [PCW-1:0] bpc, input logic hc, input logic [DW:0] hv);
    vec_t e;
    e.tid = cur_t; e.r = r; e.v = v; e.ins = ins; e.pc = p; e.cz = cz; e.pe = pe;
    e.ex = ex; e.msk = msk; e.bpc = bpc; e.hc = hc; e.hv = hv;
    tbl.push_back(e);
  endfunction

  // two reset cycles with every other input trying to provoke activity
  function automatic void add_rst();
    cur_t++;
    add(1'b1, 1'b1, OP_LOOP_OPEN, 16'd99, 1'b0, 1'b1, E_NONE, M_COMB, '0, 1'b0, '0);
    add(1'b1, 1'b1, OP_LOOP_OPEN, 16'd99, 1'b0, 1'b1, E_NONE, M_ALL, '0, 1'b1, '0);
  endfunction
  function automatic void add_i(input logic [7:0] ins, input int p, input logic cz, input logic [8:0] ex);
    add(1'b0, 1'b1, ins, PCW'(p), cz, 1'b0, ex, M_ALL, '0, 1'b0, '0);
  endfunction
  function automatic void add_ib(input logic [7:0] ins, input int p, input logic cz,
                                 input logic [8:0] ex, input int bpc);
    add(1'b0, 1'b1, ins, PCW'(p), cz, 1'b0, ex, M_ALL, PCW'(bpc), 1'b0, '0);
  endfunction
  function automatic void add_pe(input logic [8:0] ex);
    add(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b1, ex, M_ALL, '0, 1'b0, '0);
  endfunction
  function automatic void add_idle(input logic [8:0] ex, input logic hc, input int hv);
    add(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, ex, M_ALL, '0, hc, (DW+1)'(hv));
  endfunction

  vec_t       m_e;
  logic [8:0] m_got;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e   = sb.pop_front();
      m_got = {insn_ack, skipping, branch_en, stk_push_en, stk_pop_en, done, error, err_code};
      n_cmp++;
      if ((m_got & m_e.msk) !== (m_e.ex & m_e.msk)) begin
        n_bad++;
        $display("FAIL outs t%0d pc=%0d got=%b want=%b", m_e.tid, m_e.pc, m_got & m_e.msk, m_e.ex & m_e.msk);
      end
      if (m_e.ex[6]) begin
        n_cmp++;
        if (branch_pc !== m_e.bpc) begin
          n_bad++;
          $display("FAIL branch_pc t%0d got=%0d want=%0d", m_e.tid, branch_pc, m_e.bpc);
        end
      end
      if (m_e.ex[5]) begin
        n_cmp++;
        if (stk_pushd !== m_e.pc) begin
          n_bad++;
          $display("FAIL stk_pushd t%0d got=%0d want=%0d", m_e.tid, stk_pushd, m_e.pc);
        end
      end
      if (m_e.hc) begin
        n_cmp++;
        if (hwm !== hw(m_e.hv)) begin
          n_bad++;
          $display("FAIL hwm t%0d got=%0d want=%0d", m_e.tid, hwm, hw(m_e.hv));
        end
      end
      if (m_e.r && (m_e.msk == M_ALL)) begin
        n_cmp++;
        if ({branch_pc, stk_pushd} !== '0) begin
          n_bad++;
          $display("FAIL rst_data t%0d got=%h/%h want=0/0", m_e.tid, branch_pc, stk_pushd);
        end
      end
    end
  end

  initial begin
    logic [7:0] body [0:5];
    body[0] = OP_LOOP_OPEN;  body[1] = OP_LOOP_OPEN;  body[2] = OP_LOOP_CLOSE;
    body[3] = OP_LOOP_CLOSE; body[4] = OP_PLUS;       body[5] = OP_LOOP_CLOSE;

    // "+[-]": push, pop on zero cell, clean end
    add_rst();
    add_i(OP_PLUS, 0, 1'b0, E_ACK);
    add_i(OP_LOOP_OPEN, 1, 1'b0, E_PUSH);
    add_i(OP_MINUS, 2, 1'b0, E_ACK);
    add_i(OP_LOOP_CLOSE, 3, 1'b1, E_POP);
    add_pe(E_NONE);
    add_idle(E_DONE, 1'b0, 0);
    add_i(OP_PLUS, 4, 1'b0, E_DONE);

    // branch back to loop body, stack top unchanged across repeated ']'
    add_rst();
    add_i(OP_LOOP_OPEN, 10, 1'b0, E_PUSH);
    add_i(OP_PLUS, 11, 1'b0, E_ACK);
    add_ib(OP_LOOP_CLOSE, 12, 1'b0, E_BR, 11);
    add_ib(OP_LOOP_CLOSE, 12, 1'b0, E_BR, 11);
    add_i(OP_LOOP_CLOSE, 12, 1'b1, E_POP);
    add(1'b0, 1'b1, OP_LOOP_OPEN, 16'd13, 1'b0, 1'b1, E_NONE, M_ALL, '0, 1'b0, '0);
    add_idle(E_DONE, 1'b0, 0);

    // skip scan over a nested body; no stack traffic, so a later ']' is unmatched
    add_rst();
    add_i(OP_LOOP_OPEN, 0, 1'b1, E_SKIP);
    for (int i = 0; i < 6; i++) add_i(body[i], i + 1, 1'b0, E_SKIP);
    add_i(OP_PLUS, 7, 1'b0, E_ACK);
    add_i(OP_LOOP_CLOSE, 8, 1'b0, E_NONE);
    add_idle(E_ERR1, 1'b1, 0);

    // stack overflow on the 33rd open
    add_rst();
    for (int i = 0; i < 32; i++) add_i(OP_LOOP_OPEN, i, 1'b0, E_PUSH);
    add_i(OP_LOOP_OPEN, 32, 1'b0, E_NONE);
    add_idle(E_ERR2, 1'b1, 32);
    add_i(OP_LOOP_CLOSE, 33, 1'b1, E_ERR2);

    // program end with two loops open
    add_rst();
    add_i(OP_LOOP_OPEN, 0, 1'b0, E_PUSH);
    add_i(OP_LOOP_OPEN, 1, 1'b0, E_PUSH);
    add_pe(E_NONE);
    add_idle(E_ERR3, 1'b1, 2);

    // reset mid-skip returns straight to RUN
    add_rst();
    add_i(OP_LOOP_OPEN, 0, 1'b1, E_SKIP);
    add_i(OP_LOOP_OPEN, 1, 1'b0, E_SKIP);
    add_rst();
    add_i(OP_PLUS, 2, 1'b0, E_ACK);
    add_i(OP_LOOP_OPEN, 3, 1'b0, E_PUSH);

    // high-water mark survives pops
    add_rst();
    for (int i = 0; i < 3; i++) add_i(OP_LOOP_OPEN, i, 1'b0, E_PUSH);
    add_i(OP_LOOP_CLOSE, 3, 1'b1, E_POP);
    add_idle(E_NONE, 1'b1, 3);
    add_i(OP_LOOP_OPEN, 4, 1'b0, E_PUSH);
    add_idle(E_NONE, 1'b1, 3);
    add_i(OP_LOOP_OPEN, 5, 1'b0, E_PUSH);
    add_idle(E_NONE, 1'b1, 4);

    // program end while skipping
    add_rst();
    add_i(OP_LOOP_OPEN, 0, 1'b1, E_SKIP);
    add_pe(E_NONE);
    add_idle(E_ERR3, 1'b0, 0);

    // skip nesting counter overflow
    add_rst();
    add_i(OP_LOOP_OPEN, 0, 1'b1, E_SKIP);
    for (int i = 0; i < 254; i++) add_i(OP_LOOP_OPEN, i + 1, 1'b0, E_SKIP);
    add_i(OP_LOOP_OPEN, 255, 1'b0, E_SKIP);
    add_idle(E_ERR3, 1'b0, 0);
    add_i(OP_PLUS, 256, 1'b0, E_ERR3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst        = tbl[i].r;
      insn_valid = tbl[i].v;
      insn       = tbl[i].ins;
      pc         = tbl[i].pc;
      cell_zero  = tbl[i].cz;
      prog_end   = tbl[i].pe;
      sb.push_back(tbl[i]);
    end
    @(posedge clk);
    #1;
    insn_valid = 1'b0;
    prog_end   = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
